// File: rtl/fn1_div_pkg.sv
// Shared types and helpers for the fn1 sequential signed divider.
package fn1_div_pkg;

  localparam int DIN0_W = 31;
  localparam int DIN1_W = 15;
  localparam int NEG_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  // Two's-complement negate when neg is set; callers zero-extend in and truncate out.
  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v, input logic neg);
    if (neg) begin
      return ~v + NEG_W'(1);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fn1_sdiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, restore.
module fn1_sdiv_step #(
  parameter int W = 15
) (
  input  logic [W:0]   prem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   prem_o,
  output logic         q_o
);

  logic [W+1:0] shifted;
  logic [W:0]   diff;

  // Partial remainder stays below the divisor, so the shifted value fits in W+1 bits.
  always_comb begin
    shifted = {prem_i, bit_i};
    q_o     = (shifted >= {2'b00, div_i});
    diff    = shifted[W:0] - {1'b0, div_i};
    if (q_o) begin
      prem_o = diff;
    end else begin
      prem_o = shifted[W:0];
    end
  end

endmodule

// File: rtl/fn1_sdiv_seq_31s_15s.sv
// Iterative signed divider (31s / 15s) with C truncating semantics and a
// start/done handshake; all state is ce-gated.
module fn1_sdiv_seq_31s_15s
  import fn1_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [din0_WIDTH-1:0] quo,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz
);

  localparam int W0    = din0_WIDTH;
  localparam int W1    = din1_WIDTH;
  localparam int CNT_W = $clog2(W0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W0 - 1);

  // ID is an instance tag only.
  if (ID < 0) begin : g_id_tag
  end

  div_state_e       state_q, state_d;
  logic [W0-1:0]    opa_q, opa_d;
  logic [W1-1:0]    opb_q, opb_d;
  logic [W0-1:0]    dvd_q, dvd_d;
  logic [W1-1:0]    div_q, div_d;
  logic [W1:0]      prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [W0-1:0]    quo_q, quo_d;
  logic [W1-1:0]    rem_q, rem_d;

  logic [W1:0]      step_prem;
  logic             step_q;
  logic [W0-1:0]    q_full;

  fn1_sdiv_step #(.W(W1)) u_step (
    .prem_i (prem_q),
    .bit_i  (dvd_q[W0-1]),
    .div_i  (div_q),
    .prem_o (step_prem),
    .q_o    (step_q)
  );

  // Next-state logic: FSM, iteration datapath, sign fix-up and result registers.
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    dvd_d    = dvd_q;
    div_d    = div_q;
    prem_d   = prem_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    dbz_d    = dbz_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    q_full   = {dvd_q[W0-2:0], step_q};

    if (ce) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            opa_d   = din0;
            opb_d   = din1;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          sign_a_d = opa_q[W0-1];
          sign_b_d = opb_q[W1-1];
          dvd_d    = W0'(cond_neg(NEG_W'(opa_q), opa_q[W0-1]));
          div_d    = W1'(cond_neg(NEG_W'(opb_q), opb_q[W1-1]));
          prem_d   = '0;
          cnt_d    = '0;
          if (opb_q == '0) begin
            // Divide by zero skips CALC and reports straight from FIX.
            state_d = FIX;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = opa_q[W1-1:0];
          end else begin
            state_d = CALC;
          end
        end
        CALC: begin
          dvd_d  = q_full;
          prem_d = step_prem;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dbz_d   = 1'b0;
            quo_d   = W0'(cond_neg(NEG_W'(q_full), sign_a_q ^ sign_b_q));
            rem_d   = W1'(cond_neg(NEG_W'(step_prem[W1-1:0]), sign_a_q));
          end else begin
            state_d = CALC;
          end
        end
        FIX: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      dvd_q    <= '0;
      div_q    <= '0;
      prem_q   <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      dvd_q    <= dvd_d;
      div_q    <= div_d;
      prem_q   <= prem_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign quo  = quo_q;
  assign rem  = rem_q;

endmodule

// File: tb/tb_fn1_sdiv_seq_31s_15s.sv
// Directed self-checking bench for the sequential signed divider.
module tb_fn1_sdiv_seq_31s_15s;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [30:0] din0 = 31'd0;
  logic [14:0] din1 = 15'd0;
  logic        busy, done, dbz;
  logic [30:0] quo;
  logic [14:0] rem;

  int checks = 0;
  int errors = 0;

  logic [30:0] r_quo;
  logic [14:0] r_rem;
  logic        r_dbz;
  int          r_lat;

  fn1_sdiv_seq_31s_15s #(.ID(1), .din0_WIDTH(31), .din1_WIDTH(15)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .busy  (busy),
    .done  (done),
    .quo   (quo),
    .rem   (rem),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division, wait (bounded) for done, then step back into IDLE.
  task automatic run_div(input logic [30:0] a, input logic [14:0] b);
    din0  = a;
    din1  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    r_lat = 1;
    while (done !== 1'b1 && r_lat < 200) begin
      tick();
      r_lat++;
    end
    r_quo = quo;
    r_rem = rem;
    r_dbz = dbz;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (quo !== 31'd0) begin errors++; $display("FAIL reset_quo: got %h want 0", quo); end
    checks++; if (rem !== 15'd0) begin errors++; $display("FAIL reset_rem: got %h want 0", rem); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", dbz); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_signs();
    logic [30:0] av [4];
    logic [14:0] bv [4];
    logic [30:0] qv [4];
    logic [14:0] rv [4];
    av = '{31'd100, 31'h7FFF_FF9C, 31'd100, 31'h7FFF_FF9C};
    bv = '{15'd7, 15'd7, 15'h7FF9, 15'h7FF9};
    qv = '{31'd14, 31'h7FFF_FFF2, 31'h7FFF_FFF2, 31'd14};
    rv = '{15'd2, 15'h7FFE, 15'd2, 15'h7FFE};
    for (int i = 0; i < 4; i++) begin
      run_div(av[i], bv[i]);
      checks++; if (r_lat != 33) begin errors++; $display("FAIL sign%0d_latency: got %0d want 33", i, r_lat); end
      checks++; if (r_quo !== qv[i]) begin errors++; $display("FAIL sign%0d_quo: got %h want %h", i, r_quo, qv[i]); end
      checks++; if (r_rem !== rv[i]) begin errors++; $display("FAIL sign%0d_rem: got %h want %h", i, r_rem, rv[i]); end
      checks++; if (r_dbz !== 1'b0) begin errors++; $display("FAIL sign%0d_dbz: got %b want 0", i, r_dbz); end
    end
  endtask

  task automatic test_extremes();
    run_div(31'h4000_0000, 15'h7FFF);
    checks++; if (r_quo !== 31'h4000_0000) begin errors++; $display("FAIL ovf_quo: got %h want 40000000", r_quo); end
    checks++; if (r_rem !== 15'd0) begin errors++; $display("FAIL ovf_rem: got %h want 0", r_rem); end
    checks++; if (r_dbz !== 1'b0) begin errors++; $display("FAIL ovf_dbz: got %b want 0", r_dbz); end
    run_div(31'h3FFF_FFFF, 15'h4000);
    checks++; if (r_quo !== 31'h7FFF_0001) begin errors++; $display("FAIL mindiv_quo: got %h want 7fff0001", r_quo); end
    checks++; if (r_rem !== 15'h3FFF) begin errors++; $display("FAIL mindiv_rem: got %h want 3fff", r_rem); end
    checks++; if (r_lat != 33) begin errors++; $display("FAIL mindiv_latency: got %0d want 33", r_lat); end
  endtask

  task automatic test_dbz();
    run_div(31'd12345, 15'd0);
    checks++; if (r_lat != 2) begin errors++; $display("FAIL dbz_latency: got %0d want 2", r_lat); end
    checks++; if (r_quo !== 31'h7FFF_FFFF) begin errors++; $display("FAIL dbz_quo: got %h want 7fffffff", r_quo); end
    checks++; if (r_rem !== 15'd12345) begin errors++; $display("FAIL dbz_rem: got %0d want 12345", r_rem); end
    checks++; if (r_dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", r_dbz); end
  endtask

  task automatic test_ce_stall();
    int wall;
    din0  = 31'd1000;
    din1  = 15'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wall  = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_cycle1: got %b want 1", busy); end
    while (wall < 10) begin
      tick();
      wall++;
    end
    ce = 1'b0;
    repeat (5) begin
      tick();
      wall++;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || quo !== 31'h7FFF_FFFF || rem !== 15'd12345 || dbz !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got done=%b busy=%b quo=%h rem=%0d dbz=%b want 0 1 7fffffff 12345 1",
                 done, busy, quo, rem, dbz);
      end
    end
    ce = 1'b1;
    while (done !== 1'b1 && wall < 200) begin
      tick();
      wall++;
    end
    checks++; if (wall != 38) begin errors++; $display("FAIL stall_done_wall: got %0d want 38", wall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_at_done: got %b want 0", busy); end
    checks++; if (quo !== 31'd333) begin errors++; $display("FAIL stall_quo: got %0d want 333", quo); end
    checks++; if (rem !== 15'd1) begin errors++; $display("FAIL stall_rem: got %0d want 1", rem); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL stall_dbz: got %b want 0", dbz); end
    // Done must persist through a ce-low cycle and drop on the next enabled cycle.
    ce = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done_hold: got %b want 1", done); end
    ce = 1'b1;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_consume: got %b want 0", done); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int ndone;
    din0  = 31'd50;
    din1  = 15'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 10) begin
      tick();
      cyc++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
    checks++; if (quo !== 31'd0) begin errors++; $display("FAIL rstmid_quo: got %0d want 0", quo); end
    checks++; if (rem !== 15'd0) begin errors++; $display("FAIL rstmid_rem: got %0d want 0", rem); end
    ndone = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", ndone); end
    run_div(31'd50, 15'd5);
    checks++; if (r_quo !== 31'd10) begin errors++; $display("FAIL rstmid_new_quo: got %0d want 10", r_quo); end
    checks++; if (r_rem !== 15'd0) begin errors++; $display("FAIL rstmid_new_rem: got %0d want 0", r_rem); end
    checks++; if (r_lat != 33) begin errors++; $display("FAIL rstmid_new_latency: got %0d want 33", r_lat); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ndone;
    din0  = 31'd77;
    din1  = 15'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 5) begin
      tick();
      cyc++;
    end
    din0  = 31'd1000;
    din1  = 15'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc++;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 33) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 33", cyc); end
    checks++; if (quo !== 31'd9) begin errors++; $display("FAIL b2b_quo: got %0d want 9", quo); end
    checks++; if (rem !== 15'd5) begin errors++; $display("FAIL b2b_rem: got %0d want 5", rem); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_start_at_done: got busy=%b done=%b want 0 0", busy, done); end
    ndone = 0;
    repeat (45) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL b2b_extra_done: got %0d want 0", ndone); end
    checks++; if (quo !== 31'd9) begin errors++; $display("FAIL b2b_quo_hold: got %0d want 9", quo); end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_extremes();
    test_dbz();
    test_ce_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
